core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the hello_asm core.
- Fetches 32-bit instructions over a request/acknowledge instruction-memory port and holds each one in an instruction register that feeds the instruction decoder.
- Checks the decoded opcode/funct3 and steps the core through DECODE, EXEC and WB: selects the ALU operation, strobes the register-file write, advances the PC.
- Halts on an illegal instruction or a fetch timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
PC_STEP, 4, PC increment per retired instruction
FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before halting (range 2..255)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE and begins fetching
imem_req  out  1  fetch request, held until acknowledged
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  instruction register, drives the decoder instr input
opcode  in  7  decoder opcode output
funct3  in  3  decoder funct3 output
alu_sel  out  2  00 pass imm (LUI), 01 add (ADDI), 10 and (ANDI)
rf_we  out  1  register-file write enable, one cycle per instruction
pc  out  32  current program counter
retired  out  1  one-cycle pulse per completed instruction
halted  out  1  high in HALT
halt_cause  out  2  00 none, 01 illegal instruction, 10 fetch timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. State register reset to IDLE.
- Reset (rst_n low, asynchronous):
  - state = IDLE, pc = RESET_PC, instr = 0, alu_sel = 00, halt_cause = 00, timeout counter = 0.
  - imem_req, rf_we, retired and halted go low immediately, including mid-fetch or mid-writeback; no write completes.
- Moore outputs: imem_req = (state == FETCH); imem_addr = pc; rf_we = retired = (state == WB); halted = (state == HALT).
- IDLE: start high -> FETCH. start in any other state is ignored.
- FETCH:
  - Transfer occurs on a rising edge where imem_req & imem_ack.
  - On transfer: instr <= imem_rdata, counter <= 0, -> DECODE.
  - Otherwise counter increments. If counter == FETCH_TIMEOUT-1 and imem_ack is low: halt_cause <= 10, -> HALT.
  - Ack and timeout in the same cycle: the ack wins.
  - imem_ack outside FETCH is ignored.
- DECODE (decoder inputs settled from the registered instr):
  - opcode 0110111 -> alu_sel <= 00.
  - opcode 0010011, funct3 000 -> alu_sel <= 01.
  - opcode 0010011, funct3 111 -> alu_sel <= 10.
  - Any of the above -> EXEC.
  - Anything else (including instr = 0): halt_cause <= 01, -> HALT; pc holds the address of the illegal instruction.
- EXEC: one cycle for ALU settle; -> WB.
- WB:
  - rf_we = 1 and retired = 1 for exactly one cycle.
  - pc <= pc + PC_STEP, modulo 2^32 (0xFFFF_FFFC + 4 wraps to 0).
  - -> FETCH.
- rd = x0: rf_we is still asserted; the register file discards x0 writes.
- HALT: absorbing. Only rst_n exits it. instr, pc, alu_sel and halt_cause hold.
- Throughput: with ack in the first FETCH cycle, 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
- imem_req rises 1 cycle after start is sampled, and re-rises the cycle after WB.

Test Plan:
- Reset, pulse start, memory acks immediately with 0x12345037 (lui x0,0x12345) -> imem_req one cycle; alu_sel=00 in EXEC; rf_we/retired pulse 3 cycles after ack; pc 0->4; imem_req high next cycle with imem_addr=4.
- Program addi x1,x0,5 (0x00500093) then andi x2,x1,3 (0x0030F113), ack delayed 3 cycles each -> alu_sel 01 then 10; exactly two retired pulses; pc=8; imem_req held continuously during each wait.
- Fetch 0x00000033 (R-type) -> HALT the cycle after DECODE; halted=1, halt_cause=01, pc unchanged, rf_we never asserted; further acks and start ignored.
- FETCH_TIMEOUT=16, no ack -> after 16 FETCH cycles halted=1, halt_cause=10; repeat with ack on cycle 16 -> normal DECODE, no halt.
- Assert rst_n low while in WB and during an outstanding FETCH -> rf_we and imem_req drop without a clock edge; pc=RESET_PC; state IDLE until next start.
- RESET_PC=32'hFFFF_FFFC, one legal instruction -> after WB pc=0 and next imem_addr=0.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the hello_asm core: fetches into an instruction register,
// checks the decoded opcode/funct3 and steps DECODE -> EXEC -> WB, halting on faults.
module core_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned PC_STEP       = 4,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output logic [1:0]  alu_sel,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retired,
    output logic        halted,
    output logic [1:0]  halt_cause
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;
    localparam logic [2:0]  F3_ADD   = 3'b000;
    localparam logic [2:0]  F3_AND   = 3'b111;
    localparam logic [1:0]  ALU_PASS = 2'b00;
    localparam logic [1:0]  ALU_ADD  = 2'b01;
    localparam logic [1:0]  ALU_AND  = 2'b10;
    localparam logic [1:0]  HC_NONE  = 2'b00;
    localparam logic [1:0]  HC_ILL   = 2'b01;
    localparam logic [1:0]  HC_TMO   = 2'b10;
    localparam logic [7:0]  TMO_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [31:0] STEP     = 32'(PC_STEP);

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] instr_r, instr_s;
    logic [1:0]  alu_sel_r, alu_sel_s;
    logic [1:0]  halt_cause_r, halt_cause_s;
    logic [7:0]  cnt_r, cnt_s;

    // State and datapath registers; async reset also kills any in-flight fetch or write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            pc_r         <= RESET_PC;
            instr_r      <= 32'h0000_0000;
            alu_sel_r    <= ALU_PASS;
            halt_cause_r <= HC_NONE;
            cnt_r        <= 8'd0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            instr_r      <= instr_s;
            alu_sel_r    <= alu_sel_s;
            halt_cause_r <= halt_cause_s;
            cnt_r        <= cnt_s;
        end
    end

    // Next-state and next-register logic; the timeout counter only lives in FETCH.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        instr_s      = instr_r;
        alu_sel_s    = alu_sel_r;
        halt_cause_s = halt_cause_r;
        cnt_s        = 8'd0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    instr_s = imem_rdata;
                    state_s = S_DECODE;
                end else if (cnt_r == TMO_LAST) begin
                    halt_cause_s = HC_TMO;
                    state_s      = S_HALT;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_LUI) begin
                    alu_sel_s = ALU_PASS;
                    state_s   = S_EXEC;
                end else if ((opcode == OP_IMM) && (funct3 == F3_ADD)) begin
                    alu_sel_s = ALU_ADD;
                    state_s   = S_EXEC;
                end else if ((opcode == OP_IMM) && (funct3 == F3_AND)) begin
                    alu_sel_s = ALU_AND;
                    state_s   = S_EXEC;
                end else begin
                    halt_cause_s = HC_ILL;
                    state_s      = S_HALT;
                end
            end
            S_EXEC: begin
                state_s = S_WB;
            end
            S_WB: begin
                pc_s    = pc_r + STEP;
                state_s = S_FETCH;
            end
            S_HALT: begin
                state_s = S_HALT;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    assign imem_req   = (state_r == S_FETCH);
    assign imem_addr  = pc_r;
    assign instr      = instr_r;
    assign alu_sel    = alu_sel_r;
    assign rf_we      = (state_r == S_WB);
    assign retired    = (state_r == S_WB);
    assign pc         = pc_r;
    assign halted     = (state_r == S_HALT);
    assign halt_cause = halt_cause_r;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: stimulus pushes expected retire/halt events,
// a monitor pops and compares them when the DUT retires or halts.
module tb_core_seq_ctrl;

    logic        clk, rst_n, start, imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, rf_we, retired, halted;
    logic [31:0] imem_addr, instr, pc;
    logic [1:0]  alu_sel, halt_cause;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    logic        w_imem_req, w_rf_we, w_retired, w_halted;
    logic [31:0] w_imem_addr, w_instr, w_pc;
    logic [1:0]  w_alu_sel, w_halt_cause;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;

    typedef struct {
        logic        kind;   // 0 retire, 1 halt
        logic [31:0] pc;
        logic [1:0]  alu;
        logic [31:0] ins;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_ret = 0;

    // Decoder models driven from each instance's instruction register.
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];

    core_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .funct3(funct3), .alu_sel(alu_sel), .rf_we(rf_we),
        .pc(pc), .retired(retired), .halted(halted), .halt_cause(halt_cause)
    );

    core_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(w_instr), .opcode(w_opcode), .funct3(w_funct3), .alu_sel(w_alu_sel), .rf_we(w_rf_we),
        .pc(w_pc), .retired(w_retired), .halted(w_halted), .halt_cause(w_halt_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_ret(input logic [31:0] p, input logic [1:0] a, input logic [31:0] i);
        exp_t e;
        e.kind = 1'b0; e.pc = p; e.alu = a; e.ins = i; e.cause = 2'b00;
        return e;
    endfunction

    function automatic exp_t mk_halt(input logic [31:0] p, input logic [1:0] c, input logic [31:0] i);
        exp_t e;
        e.kind = 1'b1; e.pc = p; e.alu = 2'b00; e.ins = i; e.cause = c;
        return e;
    endfunction

    // Monitor: pops one expectation per retire pulse or halt entry.
    initial begin
        logic halted_prev;
        exp_t e;
        halted_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (retired) begin
                n_ret++;
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_unexpected_retire: pc 0x%08h, nothing expected", pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_kind_retire", {31'd0, 1'b0}, {31'd0, e.kind});
                    chk("sb_retire_pc", pc, e.pc);
                    chk("sb_retire_alu", {30'd0, alu_sel}, {30'd0, e.alu});
                    chk("sb_retire_instr", instr, e.ins);
                    chk("sb_retire_rf_we", {31'd0, rf_we}, 32'd1);
                end
            end
            if (halted && !halted_prev) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_unexpected_halt: cause %0d, nothing expected", halt_cause);
                end else begin
                    e = sb.pop_front();
                    chk("sb_kind_halt", {31'd0, 1'b1}, {31'd0, e.kind});
                    chk("sb_halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
                    chk("sb_halt_pc", pc, e.pc);
                    chk("sb_halt_instr", instr, e.ins);
                end
            end
            halted_prev = halted;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("req_after_start", {31'd0, imem_req}, 32'd1);
    endtask

    // Memory model: ack after 'delay' waiting FETCH cycles; returns at the DECODE negedge.
    task automatic fetch(input logic [31:0] data, input int delay);
        int guard;
        guard = 0;
        while (!imem_req && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!imem_req) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_wait: imem_req never rose within 50 cycles");
        end else begin
            for (int i = 0; i < delay; i++) begin
                chk("req_held", {31'd0, imem_req}, 32'd1);
                @(negedge clk);
            end
            imem_ack = 1'b1; imem_rdata = data;
            @(negedge clk);
            imem_ack = 1'b0; imem_rdata = 32'h0;
        end
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_alu", {30'd0, alu_sel}, 32'd0);
        chk("rst_cause", {30'd0, halt_cause}, 32'd0);
        chk("rst_outs", {28'd0, imem_req, rf_we, retired, halted}, 32'd0);
        chk("rst_w_pc", w_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req", {31'd0, imem_req}, 32'd0);

        // LUI with immediate ack
        do_start();
        chk("t1_addr0", imem_addr, 32'h0);
        sb.push_back(mk_ret(32'h0, 2'b00, 32'h1234_5037));
        fetch(32'h1234_5037, 0);
        chk("t1_req_dropped", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        chk("t1_exec_alu", {30'd0, alu_sel}, 32'd0);
        chk("t1_exec_no_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        chk("t1_wb_we", {31'd0, rf_we}, 32'd1);
        @(negedge clk);
        chk("t1_pc4", pc, 32'h4);
        chk("t1_req_again", {31'd0, imem_req}, 32'd1);
        chk("t1_addr4", imem_addr, 32'h4);

        // ADDI then ANDI with 3-cycle ack delay
        do_reset();
        do_start();
        n_ret = 0;
        sb.push_back(mk_ret(32'h0, 2'b01, 32'h0050_0093));
        fetch(32'h0050_0093, 3);
        @(negedge clk);
        chk("t2_alu_add", {30'd0, alu_sel}, 32'd1);
        sb.push_back(mk_ret(32'h4, 2'b10, 32'h0030_F113));
        fetch(32'h0030_F113, 3);
        @(negedge clk);
        chk("t2_alu_and", {30'd0, alu_sel}, 32'd2);
        repeat (2) @(negedge clk);
        chk("t2_pc8", pc, 32'h8);
        chk("t2_two_retires", n_ret, 32'd2);

        // Illegal R-type instruction
        do_reset();
        do_start();
        n_ret = 0;
        sb.push_back(mk_halt(32'h0, 2'b01, 32'h0000_0033));
        fetch(32'h0000_0033, 0);
        chk("t3_not_yet_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        chk("t3_halted", {31'd0, halted}, 32'd1);
        start = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        repeat (4) @(negedge clk);
        start = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        chk("t3_still_halted", {31'd0, halted}, 32'd1);
        chk("t3_cause_hold", {30'd0, halt_cause}, 32'd1);
        chk("t3_pc_hold", pc, 32'h0);
        chk("t3_instr_hold", instr, 32'h0000_0033);
        chk("t3_no_req", {31'd0, imem_req}, 32'd0);
        chk("t3_no_retire", n_ret, 32'd0);

        // Fetch timeout: 16 cycles without ack
        do_reset();
        do_start();
        sb.push_back(mk_halt(32'h0, 2'b10, 32'h0));
        for (int i = 0; i < 16; i++) begin
            chk("t4_req_in_fetch", {31'd0, imem_req}, 32'd1);
            @(negedge clk);
        end
        chk("t4_halted", {31'd0, halted}, 32'd1);
        chk("t4_cause", {30'd0, halt_cause}, 32'd2);

        // Ack in the 16th FETCH cycle beats the timeout
        do_reset();
        do_start();
        sb.push_back(mk_ret(32'h0, 2'b01, 32'h0050_0093));
        fetch(32'h0050_0093, 15);
        chk("t4b_not_halted", {31'd0, halted}, 32'd0);
        chk("t4b_decode_instr", instr, 32'h0050_0093);
        repeat (3) @(negedge clk);
        chk("t4b_pc4", pc, 32'h4);

        // Async reset during WB and during an outstanding fetch
        do_reset();
        do_start();
        fetch(32'h0050_0093, 0);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("t5_in_wb", {31'd0, rf_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_we_drop", {30'd0, rf_we, retired}, 32'd0);
        chk("t5_pc_reset", pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        @(posedge clk);
        #2;
        chk("t5_req_out", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_req_drop", {31'd0, imem_req}, 32'd0);
        chk("t5_pc_reset2", pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_idle", {30'd0, imem_req, halted}, 32'd0);

        // PC wrap on the RESET_PC=FFFF_FFFC instance
        do_reset();
        do_start();
        chk("t6_w_addr", w_imem_addr, 32'hFFFF_FFFC);
        sb.push_back(mk_ret(32'h0, 2'b01, 32'h0050_0093));
        fetch(32'h0050_0093, 0);
        repeat (3) @(negedge clk);
        chk("t6_w_pc_wrap", w_pc, 32'h0);
        chk("t6_w_addr_wrap", w_imem_addr, 32'h0);
        chk("t6_w_req", {31'd0, w_imem_req}, 32'd1);
        chk("t6_pc4", pc, 32'h4);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
